// File: rtl/apb_uart_pkg.sv
// Shared state type, default widths and a small index-width helper for the APB request arbiter.
package apb_uart_pkg;

   localparam int unsigned APB_AW   = 12;
   localparam int unsigned APB_DW   = 32;
   localparam int unsigned APB_NREQ = 4;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2
   } apb_mst_state_t;

   function automatic int unsigned idx_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request bit searching upward from last_gnt+1 mod N.
module rr_arbiter
   import apb_uart_pkg::*;
#(
   parameter int unsigned  N  = APB_NREQ,
   localparam int unsigned IW = idx_w(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] last_gnt,
   input  logic          enable,
   output logic [N-1:0]  gnt,
   output logic [IW-1:0] gnt_idx
);

   logic [IW-1:0] cand;
   logic          found;

   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      found   = 1'b0;
      cand    = '0;
      for (int unsigned k = 1; k <= N; k++) begin
         cand = IW'((32'(last_gnt) + k) % N);
         if (enable && !found && req[cand]) begin
            found        = 1'b1;
            gnt[cand]    = 1'b1;
            gnt_idx      = cand;
         end
      end
   end

endmodule

// File: rtl/apb_req_arbiter.sv
// Round-robin APB master sharing one port among NREQ requesters.
// Define APB_TIMEOUT_EN to end a stalled ACCESS after TIMEOUT_CYC cycles with an error.
module apb_req_arbiter
   import apb_uart_pkg::*;
#(
   parameter int unsigned  NREQ        = APB_NREQ,
   parameter int unsigned  AW          = APB_AW,
   parameter int unsigned  DW          = APB_DW,
   parameter int unsigned  TIMEOUT_CYC = 16,
   localparam int unsigned IW          = idx_w(NREQ)
) (
   input  logic               pclk,
   input  logic               preset,
   input  logic [NREQ-1:0]    req,
   input  logic [NREQ-1:0]    req_write,
   input  logic [NREQ*AW-1:0] req_addr,
   input  logic [NREQ*DW-1:0] req_wdata,
   input  logic [NREQ*4-1:0]  req_strb,
   output logic [NREQ-1:0]    done,
   output logic [DW-1:0]      rsp_rdata,
   output logic               rsp_err,
   output logic               psel,
   output logic               penable,
   output logic               pwrite,
   output logic [AW-1:0]      paddr,
   output logic [DW-1:0]      pwdata,
   output logic [3:0]         pstrb,
   input  logic               pready,
   input  logic [DW-1:0]      prdata,
   input  logic               pslverr
);

   apb_mst_state_t  state_q;
   logic [IW-1:0]   last_gnt_q;
   logic [NREQ-1:0] cur_oh;
   logic [NREQ-1:0] arb_req;
   logic [NREQ-1:0] arb_gnt;
   logic [IW-1:0]   arb_idx;
   logic            arb_en;
   logic            arb_hit;
   logic            xfer_end;
   logic            timed_out;

   assign cur_oh = NREQ'(1) << last_gnt_q;

   // The completing grantee, and a requester just given done, sit out the next pick.
   assign arb_req  = req & ~((state_q == ACCESS) ? cur_oh : done);
   assign xfer_end = pready || timed_out;
   assign arb_en   = (state_q == IDLE) || ((state_q == ACCESS) && xfer_end);
   assign arb_hit  = |arb_gnt;

   rr_arbiter #(
      .N (NREQ)
   ) u_rr (
      .req      (arb_req),
      .last_gnt (last_gnt_q),
      .enable   (arb_en),
      .gnt      (arb_gnt),
      .gnt_idx  (arb_idx)
   );

`ifdef APB_TIMEOUT_EN
   localparam int unsigned CW = $clog2(TIMEOUT_CYC + 1);
   logic [CW-1:0] tcnt_q;

   assign timed_out = (state_q == ACCESS) && !pready && (tcnt_q == CW'(TIMEOUT_CYC - 1));

   always_ff @(posedge pclk) begin
      if (preset || (state_q != ACCESS)) begin
         tcnt_q <= '0;
      end else if (!pready) begin
         tcnt_q <= tcnt_q + CW'(1);
      end
   end
`else
   logic unused_timeout;
   assign timed_out      = 1'b0;
   assign unused_timeout = ^TIMEOUT_CYC;
`endif

   always_ff @(posedge pclk) begin
      if (preset) begin
         state_q    <= IDLE;
         last_gnt_q <= IW'(NREQ - 1);
         psel       <= 1'b0;
         penable    <= 1'b0;
         pwrite     <= 1'b0;
         paddr      <= '0;
         pwdata     <= '0;
         pstrb      <= '0;
         done       <= '0;
         rsp_rdata  <= '0;
         rsp_err    <= 1'b0;
      end else begin
         done      <= '0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
         unique case (state_q)
            IDLE: ;
            SETUP: begin
               state_q <= ACCESS;
               penable <= 1'b1;
            end
            ACCESS: begin
               if (xfer_end) begin
                  done      <= cur_oh;
                  rsp_err   <= timed_out | pslverr;
                  rsp_rdata <= (pready && !pwrite) ? prdata : '0;
                  state_q   <= IDLE;
                  psel      <= 1'b0;
                  penable   <= 1'b0;
               end
            end
            default: state_q <= IDLE;
         endcase
         // A new grant overrides the IDLE return, giving back-to-back SETUP.
         if (arb_hit) begin
            state_q    <= SETUP;
            psel       <= 1'b1;
            penable    <= 1'b0;
            last_gnt_q <= arb_idx;
            pwrite     <= req_write[arb_idx];
            paddr      <= req_addr[arb_idx*AW +: AW];
            pwdata     <= req_wdata[arb_idx*DW +: DW];
            pstrb      <= req_write[arb_idx] ? req_strb[arb_idx*4 +: 4] : 4'h0;
         end
      end
   end

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Randomised bench for apb_req_arbiter against a transaction-level protocol model.
module tb_apb_req_arbiter;

   localparam int NREQ = 4;
   localparam int AW   = 12;
   localparam int DW   = 32;
   localparam int TO   = 16;
`ifdef APB_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   logic               pclk = 1'b0;
   logic               preset;
   logic [NREQ-1:0]    req, req_write, done;
   logic [NREQ*AW-1:0] req_addr;
   logic [NREQ*DW-1:0] req_wdata;
   logic [NREQ*4-1:0]  req_strb;
   logic [DW-1:0]      rsp_rdata, pwdata, prdata;
   logic               rsp_err, psel, penable, pwrite, pready, pslverr;
   logic [AW-1:0]      paddr;
   logic [3:0]         pstrb;

   always #5 pclk = ~pclk;

   apb_req_arbiter #(
      .NREQ (NREQ), .AW (AW), .DW (DW), .TIMEOUT_CYC (TO)
   ) dut (
      .pclk (pclk), .preset (preset), .req (req), .req_write (req_write),
      .req_addr (req_addr), .req_wdata (req_wdata), .req_strb (req_strb),
      .done (done), .rsp_rdata (rsp_rdata), .rsp_err (rsp_err),
      .psel (psel), .penable (penable), .pwrite (pwrite), .paddr (paddr),
      .pwdata (pwdata), .pstrb (pstrb), .pready (pready), .prdata (prdata),
      .pslverr (pslverr)
   );

   int tests_run = 0;
   int tests_failed = 0;
   int cyc = 0;

   // Requester-side record of each outstanding transaction, captured when it was raised.
   logic [NREQ-1:0] t_busy, just_done;
   logic            t_write [NREQ];
   logic [AW-1:0]   t_addr  [NREQ];
   logic [DW-1:0]   t_wdata [NREQ];
   logic [3:0]      t_strb  [NREQ];

   // Model: phase 0 idle, 1 select, 2 enable; expected outputs for the current cycle.
   int              m_phase, m_g, m_ptr, m_tcnt;
   logic            e_psel, e_pen, e_pwrite, e_err;
   logic [AW-1:0]   e_paddr;
   logic [DW-1:0]   e_pwdata, e_rdata;
   logic [3:0]      e_pstrb;
   logic [NREQ-1:0] e_done;
   int              grant_log [$];

   int              slv_mode, acc_run, auto_pct, drop_pct;
   logic [DW-1:0]   slv_data;
   logic            slv_err;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s @cyc %0d: got 0x%0h, expected 0x%0h", tag, cyc, got, exp);
      end
   endtask

   function automatic int pick(input logic [NREQ-1:0] v, input int from);
      int idx;
      for (int k = 1; k <= NREQ; k++) begin
         idx = (from + k) % NREQ;
         if (v[idx]) return idx;
      end
      return -1;
   endfunction

   task automatic raise(input int i, input logic w, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input logic [3:0] s);
      req[i] = 1'b1;
      req_write[i] = w;
      req_addr[i*AW +: AW] = a;
      req_wdata[i*DW +: DW] = d;
      req_strb[i*4 +: 4] = s;
      t_busy[i] = 1'b1;
      t_write[i] = w;
      t_addr[i] = a;
      t_wdata[i] = d;
      t_strb[i] = s;
   endtask

   task automatic raise_rand(input int i);
      logic [AW-1:0] a;
      logic [3:0]    s;
      a = AW'($urandom);
      s = 4'($urandom);
      raise(i, 1'($urandom_range(1)), a, $urandom, s);
   endtask

   task automatic grant(input int i);
      m_g = i;
      m_ptr = i;
      m_phase = 1;
      e_psel = 1'b1;
      e_pen = 1'b0;
      e_pwrite = t_write[i];
      e_paddr = t_addr[i];
      e_pwdata = t_wdata[i];
      e_pstrb = t_write[i] ? t_strb[i] : 4'h0;
      grant_log.push_back(i);
   endtask

   task automatic model_step();
      int nxt;
      if (preset) begin
         m_phase = 0; m_ptr = NREQ - 1; m_tcnt = 0;
         e_psel = 0; e_pen = 0; e_pwrite = 0; e_paddr = '0; e_pwdata = '0; e_pstrb = '0;
         e_done = '0; e_rdata = '0; e_err = 0;
         for (int i = 0; i < NREQ; i++) begin
            if (t_busy[i]) begin
               req_write[i] = t_write[i];
               req_addr[i*AW +: AW] = t_addr[i];
               req_wdata[i*DW +: DW] = t_wdata[i];
               req_strb[i*4 +: 4] = t_strb[i];
            end
         end
         return;
      end
      e_done = '0;
      e_rdata = '0;
      e_err = 1'b0;
      case (m_phase)
         0: begin
            nxt = pick(req, m_ptr);
            if (nxt >= 0) grant(nxt);
         end
         1: begin
            m_phase = 2;
            e_pen = 1'b1;
            m_tcnt = 0;
         end
         default: begin
            if (pready || (TO_EN && (m_tcnt + 1 >= TO))) begin
               e_done[m_g] = 1'b1;
               e_err = pready ? pslverr : 1'b1;
               e_rdata = (pready && !t_write[m_g]) ? prdata : '0;
               nxt = pick(req & ~e_done, m_ptr);
               if (nxt >= 0) grant(nxt);
               else begin
                  m_phase = 0;
                  e_psel = 1'b0;
                  e_pen = 1'b0;
               end
            end else begin
               m_tcnt++;
            end
         end
      endcase
   endtask

   task automatic tick_begin();
      @(negedge pclk);
      cyc++;
      check_eq("psel", psel, e_psel);
      check_eq("penable", penable, e_pen);
      check_eq("done", done, e_done);
      check_eq("rsp_rdata", rsp_rdata, e_rdata);
      check_eq("rsp_err", rsp_err, e_err);
      if (e_psel) begin
         check_eq("pwrite", pwrite, e_pwrite);
         check_eq("paddr", paddr, e_paddr);
         check_eq("pwdata", pwdata, e_pwdata);
         check_eq("pstrb", pstrb, e_pstrb);
      end
      just_done = e_done;
      for (int i = 0; i < NREQ; i++) begin
         if (e_done[i]) begin
            t_busy[i] = 1'b0;
            req[i] = 1'b0;
         end
      end
   endtask

   task automatic tick_end();
      for (int i = 0; i < NREQ; i++) begin
         if (auto_pct > 0 && !t_busy[i] && !just_done[i] && !preset &&
             $urandom_range(99) < auto_pct) raise_rand(i);
      end
      if (drop_pct > 0 && m_phase == 2 && $urandom_range(99) < drop_pct) req[m_g] = 1'b0;
      if (m_phase != 0 && t_busy[m_g]) begin
         req_write[m_g] = 1'($urandom);
         req_addr[m_g*AW +: AW] = AW'($urandom);
         req_wdata[m_g*DW +: DW] = $urandom;
         req_strb[m_g*4 +: 4] = 4'($urandom);
      end
      acc_run = (psel && penable) ? acc_run + 1 : 0;
      case (slv_mode)
         0: begin
            pready = 1'($urandom_range(1));
            prdata = $urandom;
            pslverr = ($urandom_range(7) == 0);
         end
         1: begin pready = 1'b1; prdata = slv_data; pslverr = slv_err; end
         2: begin pready = 1'b0; prdata = $urandom; pslverr = 1'b0; end
         default: begin pready = (acc_run > 3); prdata = slv_data; pslverr = 1'b0; end
      endcase
      model_step();
   endtask

   task automatic tick();
      tick_begin();
      tick_end();
   endtask

   task automatic wait_done(input int i, input int bound, output int at);
      at = -1;
      for (int n = 0; n < bound && at < 0; n++) begin
         tick();
         if (done[i]) at = cyc;
      end
      if (at < 0) check_eq("wait_done", done[i], 1'b1);
   endtask

   task automatic drain(input int bound);
      for (int n = 0; n < bound && (t_busy != '0 || m_phase != 0); n++) tick();
      check_eq("drain_busy", t_busy, '0);
   endtask

   task automatic do_reset();
      tick_begin(); preset = 1'b1; tick_end();
      tick_begin(); preset = 1'b0; tick_end();
   endtask

   int c0, at, log0, gaps;

   initial begin
      preset = 1'b1;
      req = '0; req_write = '0; req_addr = '0; req_wdata = '0; req_strb = '0;
      pready = 1'b0; prdata = '0; pslverr = 1'b0;
      slv_mode = 1; slv_data = '0; slv_err = 1'b0; acc_run = 0; auto_pct = 0; drop_pct = 0;
      t_busy = '0; just_done = '0;
      for (int i = 0; i < NREQ; i++) begin
         t_write[i] = 0; t_addr[i] = '0; t_wdata[i] = '0; t_strb[i] = '0;
      end
      m_phase = 0; m_g = 0; m_ptr = NREQ - 1; m_tcnt = 0;
      e_psel = 0; e_pen = 0; e_pwrite = 0; e_paddr = '0; e_pwdata = '0; e_pstrb = '0;
      e_done = '0; e_rdata = '0; e_err = 0;
      tick();
      tick();
      tick_begin(); preset = 1'b0; tick_end();

      // Single write: SETUP at +1, ACCESS at +2, done at +3.
      tick_begin(); raise(0, 1'b1, 12'h010, 32'h0000_00A5, 4'hF); c0 = cyc; tick_end();
      wait_done(0, 10, at);
      check_eq("t1_latency", at - c0, 3);
      check_eq("t1_err", rsp_err, 1'b0);
      drain(10);

      // Read with three wait states.
      slv_mode = 3; slv_data = 32'h0000_1234;
      tick_begin(); raise(2, 1'b0, 12'h004, 32'hDEAD_BEEF, 4'hF); c0 = cyc; tick_end();
      wait_done(2, 20, at);
      check_eq("t2_latency", at - c0, 6);
      check_eq("t2_rdata", rsp_rdata, 32'h0000_1234);
      drain(10);

      // Contention from reset: fixed rotation, psel never drops.
      slv_mode = 1; slv_data = 32'h5555_AAAA;
      do_reset();
      log0 = grant_log.size();
      tick_begin();
      for (int i = 0; i < NREQ; i++) raise_rand(i);
      tick_end();
      auto_pct = 100;
      gaps = 0;
      for (int n = 0; n < 80 && grant_log.size() < log0 + 12; n++) begin
         tick();
         if (!psel) gaps++;
      end
      check_eq("t3_gaps", gaps, 0);
      for (int k = 0; k < 12 && log0 + k < grant_log.size(); k++)
         check_eq("t3_order", grant_log[log0 + k], k % NREQ);
      auto_pct = 0;
      drain(40);

      // Slave error on a write, then a clean back-to-back read.
      slv_err = 1'b1; slv_data = 32'hCAFE_0003;
      tick_begin(); raise(1, 1'b1, 12'hFFC, 32'h1111_2222, 4'h3); tick_end();
      tick_begin(); raise(3, 1'b0, 12'h0F0, 32'h0, 4'h0); tick_end();
      wait_done(1, 10, at);
      check_eq("t4_err", rsp_err, 1'b1);
      slv_err = 1'b0;
      tick();
      check_eq("t4_pulse", done[1], 1'b0);
      wait_done(3, 10, at);
      check_eq("t4_next_err", rsp_err, 1'b0);
      check_eq("t4_next_rdata", rsp_rdata, 32'hCAFE_0003);
      drain(10);

      // Reset during ACCESS: abort, then requester 0 wins first.
      slv_mode = 2;
      tick_begin();
      raise(2, 1'b0, 12'h0C0, 32'h0, 4'h0);
      raise(1, 1'b0, 12'h0B0, 32'h0, 4'h0);
      tick_end();
      tick_begin(); raise(0, 1'b1, 12'h0A0, 32'h0A0A_0A0A, 4'hC); tick_end();
      for (int n = 0; n < 10 && !penable; n++) tick();
      check_eq("t5_in_access", penable, 1'b1);
      tick_begin(); preset = 1'b1; tick_end();
      tick_begin();
      check_eq("t5_rst_psel", psel, 1'b0);
      check_eq("t5_rst_done", done, '0);
      preset = 1'b0;
      tick_end();
      tick();
      check_eq("t5_first_psel", psel, 1'b1);
      check_eq("t5_first_addr", paddr, 12'h0A0);
      slv_mode = 1;
      drain(30);

      // Slave never ready.
      slv_mode = 2;
      tick_begin(); raise(1, 1'b0, 12'h020, 32'h0, 4'h0); c0 = cyc; tick_end();
`ifdef APB_TIMEOUT_EN
      wait_done(1, 40, at);
      check_eq("t6_latency", at - c0, 2 + TO);
      check_eq("t6_err", rsp_err, 1'b1);
      check_eq("t6_rdata", rsp_rdata, '0);
`else
      for (int n = 0; n < 100; n++) tick();
      check_eq("t6_wait_psel", psel, 1'b1);
      check_eq("t6_wait_pen", penable, 1'b1);
      check_eq("t6_wait_done", done, '0);
`endif
      slv_mode = 1;
      drain(20);

      // Random traffic with random wait states, errors and grantees dropping req.
      slv_mode = 0; auto_pct = 30; drop_pct = 5;
      for (int n = 0; n < 3000; n++) tick();
      auto_pct = 0; drop_pct = 0;
      drain(300);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
